// File: rtl/stopwatch_time_core_if.sv
// stopwatch_time_core_if: control/display bundle between the stopwatch FSM side and the time core
// master drives running, display_select, lap_pulse, clear_pulse and reads the display outputs.
// slave is the time core, which drives disp_time, disp_valid, lap_count, tick, overflow.
interface stopwatch_time_core_if;
  logic        running;
  logic [1:0]  display_select;
  logic        lap_pulse;
  logic        clear_pulse;
  logic [23:0] disp_time;
  logic        disp_valid;
  logic [1:0]  lap_count;
  logic        tick;
  logic        overflow;
  modport master (
    output running, display_select, lap_pulse, clear_pulse,
    input  disp_time, disp_valid, lap_count, tick, overflow
  );
  modport slave (
    input  running, display_select, lap_pulse, clear_pulse,
    output disp_time, disp_valid, lap_count, tick, overflow
  );
endinterface

// File: rtl/stopwatch_time_core.sv
// stopwatch_time_core: centisecond prescaler, BCD MM:SS:CC counter, two lap snapshots, registered display mux
// Ports: clk, rst (sync, active-high); sw (slave modport) carries running, display_select,
// lap_pulse, clear_pulse in and disp_time, disp_valid, lap_count, tick, overflow out.
// STOPWATCH_SATURATE_EN: when defined the count sticks at 59:59.99 instead of wrapping.
module stopwatch_time_core #(
  parameter int TICK_DIV = 500000
) (
  input logic clk,
  input logic rst,
  stopwatch_time_core_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] presc;
  logic [23:0]   live, lap1, lap2, live_inc, next_live;
  logic          lap1_valid, lap2_valid, tick_w, wrap;
  // Digit order LSB first: cs_u, cs_t, sec_u, sec_t, min_u, min_t; tens of sec/min roll at 5.
  function automatic logic [24:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    logic [3:0]  lim;
    logic        c;
    n = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (c) begin
        n[i*4+:4] = (t[i*4+:4] == lim) ? 4'd0 : t[i*4+:4] + 4'd1;
        c = (t[i*4+:4] == lim);
      end
    end
    return {c, n};
  endfunction
  always_comb begin
    tick_w = sw.running && (presc == PW'(TICK_DIV - 1));
    {wrap, live_inc} = bcd_inc(live);
`ifdef STOPWATCH_SATURATE_EN
    next_live = wrap ? live : live_inc;
`else
    next_live = live_inc;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      live          <= '0;
      lap1          <= '0;
      lap2          <= '0;
      lap1_valid    <= 1'b0;
      lap2_valid    <= 1'b0;
      sw.lap_count  <= 2'd0;
      sw.disp_time  <= '0;
      sw.disp_valid <= 1'b1;
      sw.tick       <= 1'b0;
      sw.overflow   <= 1'b0;
    end else begin
      sw.tick       <= tick_w;
      sw.disp_time  <= (sw.display_select == 2'b01) ? (lap1_valid ? lap1 : '0) :
                       (sw.display_select == 2'b10) ? (lap2_valid ? lap2 : '0) : live;
      sw.disp_valid <= (sw.display_select == 2'b01) ? lap1_valid :
                       (sw.display_select == 2'b10) ? lap2_valid : 1'b1;
      if (sw.clear_pulse && !sw.running) begin
        presc        <= '0;
        live         <= '0;
        lap1         <= '0;
        lap2         <= '0;
        lap1_valid   <= 1'b0;
        lap2_valid   <= 1'b0;
        sw.lap_count <= 2'd0;
        sw.overflow  <= 1'b0;
      end else begin
        if (sw.running) presc <= tick_w ? '0 : presc + 1'b1;
        if (tick_w) live <= next_live;
        if (tick_w && wrap) sw.overflow <= 1'b1;
        // Laps sample live before this cycle's increment lands.
        if (sw.lap_pulse && sw.running) begin
          if (sw.lap_count == 2'd0) begin
            lap1         <= live;
            lap1_valid   <= 1'b1;
            sw.lap_count <= 2'd1;
          end else if (sw.lap_count == 2'd1) begin
            lap2         <= live;
            lap2_valid   <= 1'b1;
            sw.lap_count <= 2'd2;
          end else begin
            lap1 <= lap2;
            lap2 <= live;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_time_core.sv
// tb_stopwatch_time_core: directed self-checking bench for stopwatch_time_core with TICK_DIV = 4
module tb_stopwatch_time_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
`ifdef STOPWATCH_SATURATE_EN
  localparam logic [23:0] WRAP_EXP  = 24'h595999;
  localparam logic [23:0] AFTER_EXP = 24'h595999;
`else
  localparam logic [23:0] WRAP_EXP  = 24'h000000;
  localparam logic [23:0] AFTER_EXP = 24'h000001;
`endif
  stopwatch_time_core_if sw();
  stopwatch_time_core #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .sw(sw));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    sw.running = 1'b0;
    sw.display_select = 2'b00;
    sw.lap_pulse = 1'b0;
    sw.clear_pulse = 1'b0;
    step(2);
    checks++; if (sw.disp_time !== 24'h000000) begin errors++; $display("FAIL reset_disp got=%h exp=000000", sw.disp_time); end
    checks++; if (sw.disp_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got=%b exp=1", sw.disp_valid); end
    checks++; if (sw.lap_count !== 2'd0) begin errors++; $display("FAIL reset_lapcnt got=%0d exp=0", sw.lap_count); end
    checks++; if ({sw.tick, sw.overflow} !== 2'b00) begin errors++; $display("FAIL reset_tick_ovf got=%b exp=00", {sw.tick, sw.overflow}); end
  endtask
  task automatic test_count;
    rst = 1'b0;
    sw.running = 1'b1;
    step(3);
    checks++; if (sw.tick !== 1'b0) begin errors++; $display("FAIL early_tick got=%b exp=0", sw.tick); end
    step(1);
    checks++; if (sw.tick !== 1'b1) begin errors++; $display("FAIL first_tick got=%b exp=1", sw.tick); end
    step(1);
    checks++; if (sw.disp_time !== 24'h000001) begin errors++; $display("FAIL first_disp got=%h exp=000001", sw.disp_time); end
    checks++; if (sw.tick !== 1'b0) begin errors++; $display("FAIL tick_width got=%b exp=0", sw.tick); end
    step(396);
    checks++; if (sw.disp_time !== 24'h000100) begin errors++; $display("FAIL disp_100 got=%h exp=000100", sw.disp_time); end
  endtask
  task automatic test_stop_resume;
    step(601);
    checks++; if (sw.disp_time !== 24'h000250) begin errors++; $display("FAIL disp_250 got=%h exp=000250", sw.disp_time); end
    sw.running = 1'b0;
    step(10);
    checks++; if (sw.disp_time !== 24'h000250) begin errors++; $display("FAIL hold_250 got=%h exp=000250", sw.disp_time); end
    sw.running = 1'b1;
    step(1);
    checks++; if (sw.tick !== 1'b0) begin errors++; $display("FAIL resume_early got=%b exp=0", sw.tick); end
    step(1);
    checks++; if (sw.tick !== 1'b1) begin errors++; $display("FAIL resume_partial_tick got=%b exp=1", sw.tick); end
    step(1);
    checks++; if (sw.disp_time !== 24'h000251) begin errors++; $display("FAIL disp_251 got=%h exp=000251", sw.disp_time); end
  endtask
  task automatic test_laps;
    sw.running = 1'b0;
    sw.clear_pulse = 1'b1;
    step(1);
    sw.clear_pulse = 1'b0;
    sw.running = 1'b1;
    step(493);
    sw.lap_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    checks++; if (sw.lap_count !== 2'd1) begin errors++; $display("FAIL lapcnt_1 got=%0d exp=1", sw.lap_count); end
    step(507);
    sw.lap_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    step(199);
    sw.lap_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    checks++; if (sw.lap_count !== 2'd2) begin errors++; $display("FAIL lapcnt_2 got=%0d exp=2", sw.lap_count); end
    sw.display_select = 2'b01;
    step(1);
    checks++; if ({sw.disp_valid, sw.disp_time} !== {1'b1, 24'h000250}) begin errors++; $display("FAIL lap1_shift got=%b/%h exp=1/000250", sw.disp_valid, sw.disp_time); end
    sw.display_select = 2'b10;
    step(1);
    checks++; if ({sw.disp_valid, sw.disp_time} !== {1'b1, 24'h000300}) begin errors++; $display("FAIL lap2_shift got=%b/%h exp=1/000300", sw.disp_valid, sw.disp_time); end
    sw.display_select = 2'b00;
  endtask
  task automatic test_lap_on_tick;
    sw.running = 1'b0;
    sw.clear_pulse = 1'b1;
    step(1);
    sw.clear_pulse = 1'b0;
    sw.running = 1'b1;
    step(39);
    sw.lap_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    sw.display_select = 2'b01;
    step(1);
    checks++; if (sw.disp_time !== 24'h000009) begin errors++; $display("FAIL lap_on_tick got=%h exp=000009", sw.disp_time); end
    sw.display_select = 2'b00;
    step(1);
    checks++; if (sw.disp_time !== 24'h000010) begin errors++; $display("FAIL live_after_lap got=%h exp=000010", sw.disp_time); end
  endtask
  task automatic test_clear;
    sw.clear_pulse = 1'b1;
    step(1);
    sw.clear_pulse = 1'b0;
    step(2);
    checks++; if (sw.disp_time !== 24'h000011) begin errors++; $display("FAIL clear_running_time got=%h exp=000011", sw.disp_time); end
    checks++; if (sw.lap_count !== 2'd1) begin errors++; $display("FAIL clear_running_laps got=%0d exp=1", sw.lap_count); end
    sw.running = 1'b0;
    sw.lap_pulse = 1'b1;
    sw.clear_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    sw.clear_pulse = 1'b0;
    checks++; if ({sw.lap_count, sw.overflow} !== 3'b000) begin errors++; $display("FAIL clear_stopped got=%b exp=000", {sw.lap_count, sw.overflow}); end
    sw.display_select = 2'b01;
    step(1);
    checks++; if ({sw.disp_valid, sw.disp_time} !== 25'd0) begin errors++; $display("FAIL clear_lap1 got=%b/%h exp=0/000000", sw.disp_valid, sw.disp_time); end
    sw.display_select = 2'b00;
    step(1);
    checks++; if ({sw.disp_valid, sw.disp_time} !== {1'b1, 24'h000000}) begin errors++; $display("FAIL clear_live got=%b/%h exp=1/000000", sw.disp_valid, sw.disp_time); end
    sw.lap_pulse = 1'b1;
    step(1);
    sw.lap_pulse = 1'b0;
    checks++; if (sw.lap_count !== 2'd0) begin errors++; $display("FAIL lap_stopped got=%0d exp=0", sw.lap_count); end
  endtask
  task automatic test_overflow;
    force dut.live = 24'h595999;
    #1;
    release dut.live;
    sw.running = 1'b1;
    step(3);
    checks++; if (sw.disp_time !== 24'h595999) begin errors++; $display("FAIL preload got=%h exp=595999", sw.disp_time); end
    checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", sw.overflow); end
    step(1);
    checks++; if (sw.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", sw.overflow); end
    step(1);
    checks++; if (sw.disp_time !== WRAP_EXP) begin errors++; $display("FAIL wrap got=%h exp=%h", sw.disp_time, WRAP_EXP); end
    step(4);
    checks++; if ({sw.overflow, sw.disp_time} !== {1'b1, AFTER_EXP}) begin errors++; $display("FAIL after_wrap got=%b/%h exp=1/%h", sw.overflow, sw.disp_time, AFTER_EXP); end
  endtask
  initial begin
    test_reset();
    test_count();
    test_stop_resume();
    test_laps();
    test_lap_on_tick();
    test_clear();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stopwatch_time_core.md
Name: stopwatch_time_core

Overview:
Downstream datapath for the stopwatch control FSM. It consumes `running` and `display_select` from the control FSM, plus a one-cycle lap pulse and a clear pulse. It keeps a BCD MM:SS:CC time count, captures two lap snapshots and drives a registered 24-bit BCD display word to the seven-segment driver.

Parameters:
TICK_DIV, 500000, number of clk cycles per centisecond tick (100 Hz at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
running  input  1  from control FSM; 1 = timebase advances
display_select  input  2  from control FSM; 00 = live, 01 = lap1, 10 = lap2, 11 = live
lap_pulse  input  1  single-cycle lap capture request (already edge-detected)
clear_pulse  input  1  single-cycle clear request (already edge-detected)
disp_time  output  24  BCD {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits per digit
disp_valid  output  1  selected source holds valid data
lap_count  output  2  number of laps captured since last clear (0..2, saturates)
tick  output  1  one-cycle pulse on each centisecond increment
overflow  output  1  sticky; set on wrap past 59:59.99

Behaviour:
- Reset (rst = 1 at posedge clk):
  - Prescaler, all time digits, lap1, lap2, lap_count, disp_time, tick and overflow all go to 0.
  - lap1_valid and lap2_valid clear; disp_valid = 1 (live is always valid).
- Prescaler:
  - Counts 0..TICK_DIV-1 only while running = 1.
  - At TICK_DIV-1 it returns to 0 and tick pulses high for that one cycle.
  - While running = 0 it holds its value, so a partial tick is preserved across stop/start.
- Time counter: on each tick, ripple BCD increment.
  - cs_u 9→0 carries to cs_t; cs_t 9→0 carries to sec_u; sec_u 9→0 carries to sec_t.
  - sec_t 5→0 carries to min_u; min_u 9→0 carries to min_t; min_t 5→0 is a full wrap.
  - Full wrap: 59:59.99 → 00:00.00 and overflow is set.
  - Digits never hold non-BCD values; each digit is 4 bits wide.
- Lap capture, on lap_pulse while running = 1:
  - lap_count 0: live → lap1, lap1_valid set, lap_count = 1.
  - lap_count 1: live → lap2, lap2_valid set, lap_count = 2.
  - lap_count 2: lap1 ← lap2, lap2 ← live (shift, most recent kept in lap2); lap_count stays 2.
  - Captured value is the register value before that cycle's tick, i.e. same-cycle tick and lap captures the pre-increment time.
  - lap_pulse while running = 0 is ignored.
- Clear, on clear_pulse while running = 0:
  - Prescaler, time, laps, valid flags, lap_count and overflow all go to 0.
  - clear_pulse while running = 1 is ignored.
  - clear_pulse and lap_pulse in the same cycle while stopped: clear applies.
- Display mux is registered with 1 cycle latency from display_select, or from any source change, to disp_time.
  - Live (00/11): disp_valid = 1.
  - 01: disp_time = lap1, disp_valid = lap1_valid.
  - 10: disp_time = lap2, disp_valid = lap2_valid.
  - An invalid lap source drives disp_time = 0.
- running may deassert on any cycle, including the tick cycle. A tick that is pulsed in that cycle still applies.

Optional Feature:
Macro STOPWATCH_SATURATE_EN.
- Defined:
  - The counter saturates at 59:59.99 instead of wrapping.
  - At saturation, further ticks leave the time unchanged, tick still pulses and overflow sets on the first saturated tick.
  - Clear is still required to restart.
- Undefined: wrap-around to 00:00.00 as above.

Test Plan:
- TICK_DIV = 4, rst high 2 cycles, then low with running = 1 → first tick on the 4th cycle after release; disp_time = 24'h000001 one cycle later; after 100 ticks disp_time = 24'h000100.
- Run to 250 ticks, drop running for 10 cycles, raise again → time holds at 24'h000250 while stopped; the next tick arrives after the remaining prescaler count, not a full TICK_DIV.
- Preload-by-run to 59:59.99 (24'h595999), one more tick → 24'h000000 with overflow = 1. With STOPWATCH_SATURATE_EN: stays 24'h595999 with overflow = 1.
- Lap at 00:01.23, then 00:02.50, then 00:03.00, with display_select = 01 and then 10 → lap1 = 24'h000250, lap2 = 24'h000300, lap_count = 2; disp_valid = 1 for both.
- lap_pulse on the same cycle as a tick at 24'h000009 → the captured lap = 24'h000009 while live advances to 24'h000010.
- clear_pulse while running → no change. Stop, then clear_pulse → time, laps and overflow = 0, lap_count = 0; display_select = 01 gives disp_time = 0 and disp_valid = 0.
